// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
// Frame = start bit, 5..DBIT_MAX data bits (LSB first), optional even/odd
// parity, then 1, 1.5 or 2 stop bits. Bit timing comes from an external
// s_tick strobe, OVS ticks per bit period. Frame configuration is captured
// when a request is accepted, so inputs may change while a frame is in flight.
// Optional feature: define UART_TX_BREAK_EN to add the send_break input and
// the BREAK state (long low line followed by one high bit period).
module uart_tx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OVS      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                tx_start,
`ifdef UART_TX_BREAK_EN
  input  logic                send_break,
`endif
  input  logic [DBIT_MAX-1:0] din,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic [1:0]          cfg_stop,
  output logic                tx_busy,
  output logic                tx_done_tick,
  output logic                tx
);

  // Tick counter spans the longest stop period (2*OVS ticks).
  localparam int SW = $clog2(2 * OVS);
  // Bit counter also covers break length: up to 2*(1+9+1+1) bit periods.
  localparam int NW = 5;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_BREAK_EN
  localparam logic [2:0] BREAK  = 3'd5;
`endif

  localparam logic [SW-1:0] S_ZERO      = SW'(0);
  localparam logic [SW-1:0] S_ONE       = SW'(1);
  localparam logic [SW-1:0] BIT_LAST    = SW'(OVS - 1);
  localparam logic [SW-1:0] STOP1_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] STOP15_LAST = SW'((3 * OVS) / 2 - 1);
  localparam logic [SW-1:0] STOP2_LAST  = SW'(2 * OVS - 1);
  localparam logic [NW-1:0] N_ZERO      = NW'(0);
  localparam logic [NW-1:0] N_ONE       = NW'(1);
  localparam logic [3:0]    DB_MIN      = 4'd5;
  localparam logic [3:0]    DB_MAX      = 4'(DBIT_MAX);

  // Out-of-range data widths are pulled into the supported 5..DBIT_MAX range.
  function automatic logic [3:0] clamp_dbits(input logic [3:0] req);
    logic [3:0] res;
    if (req < DB_MIN) begin
      res = DB_MIN;
    end else if (req > DB_MAX) begin
      res = DB_MAX;
    end else begin
      res = req;
    end
    return res;
  endfunction

  // Parity over the low nbits of data; odd=1 inverts the even result.
  function automatic logic calc_parity(input logic [DBIT_MAX-1:0] data,
                                       input logic [3:0]          nbits,
                                       input logic                odd);
    logic acc;
    acc = odd;
    for (int i = 0; i < DBIT_MAX; i++) begin
      if (4'(i) < nbits) begin
        acc = acc ^ data[i];
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  // Last tick index of the stop period; code 11 behaves like two stop bits.
  function automatic logic [SW-1:0] stop_last(input logic [1:0] sel);
    logic [SW-1:0] res;
    case (sel)
      2'b00:   res = STOP1_LAST;
      2'b01:   res = STOP15_LAST;
      default: res = STOP2_LAST;
    endcase
    return res;
  endfunction

  logic [2:0]          state_r, state_s;
  logic [SW-1:0]       s_r, s_s;
  logic [NW-1:0]       n_r, n_s;
  logic [NW-1:0]       n_last_r, n_last_s;
  logic [DBIT_MAX-1:0] shift_r, shift_s;
  logic                par_en_r, par_en_s;
  logic                par_bit_r, par_bit_s;
  logic [SW-1:0]       stop_last_r, stop_last_s;
  logic                tx_r, tx_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic [3:0]          dbits_s;
  logic                par_req_s;
  logic [NW-1:0]       brk_bits_s;

  // Next-state, counter and latched-configuration logic.
  always_comb begin
    state_s     = state_r;
    s_s         = s_r;
    n_s         = n_r;
    n_last_s    = n_last_r;
    shift_s     = shift_r;
    par_en_s    = par_en_r;
    par_bit_s   = par_bit_r;
    stop_last_s = stop_last_r;
    done_s      = 1'b0;
    dbits_s     = clamp_dbits(cfg_dbits);
    par_req_s   = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
    brk_bits_s  = NW'(dbits_s) + NW'(2) + NW'(par_req_s);

    case (state_r)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (send_break) begin
          // Low for 2*(frame bits) bit periods, then one high bit period.
          state_s     = BREAK;
          s_s         = S_ZERO;
          n_s         = N_ZERO;
          n_last_s    = {brk_bits_s[NW-2:0], 1'b0} - N_ONE;
          stop_last_s = STOP1_LAST;
        end else
`endif
        if (tx_start) begin
          state_s     = START;
          s_s         = S_ZERO;
          n_s         = N_ZERO;
          n_last_s    = NW'(dbits_s) - N_ONE;
          shift_s     = din;
          par_en_s    = par_req_s;
          par_bit_s   = calc_parity(din, dbits_s, cfg_parity == 2'b10);
          stop_last_s = stop_last(cfg_stop);
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_r == BIT_LAST) begin
            state_s = DATA;
            s_s     = S_ZERO;
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_r == BIT_LAST) begin
            s_s     = S_ZERO;
            shift_s = {1'b0, shift_r[DBIT_MAX-1:1]};
            if (n_r == n_last_r) begin
              n_s     = N_ZERO;
              state_s = par_en_r ? PARITY : STOP;
            end else begin
              n_s = n_r + N_ONE;
            end
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_r == BIT_LAST) begin
            state_s = STOP;
            s_s     = S_ZERO;
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_r == stop_last_r) begin
            state_s = IDLE;
            s_s     = S_ZERO;
            done_s  = 1'b1;
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        if (s_tick) begin
          if (s_r == BIT_LAST) begin
            s_s = S_ZERO;
            if (n_r == n_last_r) begin
              n_s     = N_ZERO;
              state_s = STOP;
            end else begin
              n_s = n_r + N_ONE;
            end
          end else begin
            s_s = s_r + S_ONE;
          end
        end else begin
          s_s = s_r;
        end
      end
`endif
      default: begin
        state_s = IDLE;
        s_s     = S_ZERO;
        n_s     = N_ZERO;
      end
    endcase
  end

  // Line level and busy flag derived from the state being entered, so the
  // registered outputs line up with that state.
  always_comb begin
    busy_s = (state_s != IDLE);
    case (state_s)
      IDLE:    tx_s = 1'b1;
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
      PARITY:  tx_s = par_bit_s;
      STOP:    tx_s = 1'b1;
`ifdef UART_TX_BREAK_EN
      BREAK:   tx_s = 1'b0;
`endif
      default: tx_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs; reset forces an idle high line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      s_r         <= S_ZERO;
      n_r         <= N_ZERO;
      n_last_r    <= N_ZERO;
      shift_r     <= {DBIT_MAX{1'b0}};
      par_en_r    <= 1'b0;
      par_bit_r   <= 1'b0;
      stop_last_r <= S_ZERO;
      tx_r        <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      s_r         <= s_s;
      n_r         <= n_s;
      n_last_r    <= n_last_s;
      shift_r     <= shift_s;
      par_en_r    <= par_en_s;
      par_bit_r   <= par_bit_s;
      stop_last_r <= stop_last_s;
      tx_r        <= tx_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign tx           = tx_r;
  assign tx_busy      = busy_r;
  assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (DBIT_MAX=8, OVS=16). Expected line levels
// are pushed per bit-tick into a queue before each frame and popped on every
// busy cycle; frame lengths are checked against hand-derived tick counts.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       tx_start;
  logic [7:0] din;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic [1:0] cfg_stop;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
`endif

  int   checks    = 0;
  int   failures  = 0;
  int   busy_cnt  = 0;
  int   done_cnt  = 0;
  bit   mon_en    = 1'b0;
  logic exp_q[$];
  int   b0;
  int   d0;

  uart_tx_cfg #(.DBIT_MAX(8), .OVS(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_start     (tx_start),
`ifdef UART_TX_BREAK_EN
    .send_break   (send_break),
`endif
    .din          (din),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop     (cfg_stop),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, pop/compare the scoreboard.
  task automatic step();
    @(negedge clk);
    if (tx_busy) busy_cnt++;
    if (tx_done_tick) done_cnt++;
    if (mon_en && tx_busy) begin
      if (exp_q.size() > 0) chk("tx_bit", {31'd0, tx}, {31'd0, exp_q.pop_front()});
      else chk("busy_past_frame", {31'd0, tx_busy}, 32'd0);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_bits(input logic v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v);
  endtask

  // Reference frame model: line level for every bit tick of one frame.
  task automatic push_frame(input logic [7:0] d, input logic [3:0] db,
                            input logic [1:0] pa, input logic [1:0] st);
    int   nb;
    logic p;
    nb = (db < 4'd5) ? 5 : ((db > 4'd8) ? 8 : int'(db));
    p  = 1'b0;
    push_bits(1'b0, 16);
    for (int i = 0; i < nb; i++) begin
      push_bits(d[i], 16);
      p = p ^ d[i];
    end
    if (pa == 2'b01) push_bits(p, 16);
    else if (pa == 2'b10) push_bits(~p, 16);
    push_bits(1'b1, (st == 2'b00) ? 16 : ((st == 2'b01) ? 24 : 32));
  endtask

  // Present a one-cycle request; called at a falling edge.
  task automatic send(input logic [7:0] d, input logic [3:0] db,
                      input logic [1:0] pa, input logic [1:0] st);
    din = d; cfg_dbits = db; cfg_parity = pa; cfg_stop = st;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int dstart;
    dstart = done_cnt;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done_cnt != dstart) break;
    end
    chk(tag, done_cnt - dstart, 32'd1);
  endtask

  initial begin
    reset = 1'b1; s_tick = 1'b1; tx_start = 1'b0; din = 8'h00;
    cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    steps(3);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done_tick}, 32'd0);
    reset = 1'b0;
    steps(2);
    mon_en = 1'b1;

    // 8N1, 0xA5: 160 ticks.
    b0 = busy_cnt;
    push_frame(8'hA5, 4'd8, 2'b00, 2'b00);
    send(8'hA5, 4'd8, 2'b00, 2'b00);
    wait_done(400, "done_8n1");
    chk("len_8n1", busy_cnt - b0, 32'd160);
    chk("busy_end_8n1", {31'd0, tx_busy}, 32'd0);
    step();
    chk("done_one_clk", {31'd0, tx_done_tick}, 32'd0);

    // 7E2, 0xFF: parity 1, 176 ticks, din[7] never sent.
    b0 = busy_cnt;
    push_frame(8'hFF, 4'd7, 2'b01, 2'b10);
    send(8'hFF, 4'd7, 2'b01, 2'b10);
    wait_done(400, "done_7e2");
    chk("len_7e2", busy_cnt - b0, 32'd176);
    chk("q_7e2", exp_q.size(), 32'd0);

    // 5O1.5, low bits 00011 with junk above; config changed mid-frame.
    b0 = busy_cnt;
    push_frame(8'hE3, 4'd5, 2'b10, 2'b01);
    send(8'hE3, 4'd5, 2'b10, 2'b01);
    steps(40);
    din = 8'h00; cfg_dbits = 4'd8; cfg_parity = 2'b01; cfg_stop = 2'b00;
    wait_done(400, "done_5o15");
    chk("len_5o15", busy_cnt - b0, 32'd136);

    // Clamp low (2 -> 5), parity 11 = none, stop 11 = two: 128 ticks.
    b0 = busy_cnt;
    push_frame(8'h35, 4'd2, 2'b11, 2'b11);
    send(8'h35, 4'd2, 2'b11, 2'b11);
    wait_done(400, "done_clamp_lo");
    chk("len_clamp_lo", busy_cnt - b0, 32'd128);

    // Clamp high (15 -> 8), even parity of 0x81 = 0: 176 ticks.
    b0 = busy_cnt;
    push_frame(8'h81, 4'd15, 2'b01, 2'b00);
    send(8'h81, 4'd15, 2'b01, 2'b00);
    wait_done(400, "done_clamp_hi");
    chk("len_clamp_hi", busy_cnt - b0, 32'd176);

    // Back-to-back with tx_start held, then stray pulses while busy.
    b0 = busy_cnt; d0 = done_cnt;
    push_frame(8'h3C, 4'd8, 2'b00, 2'b00);
    push_frame(8'h3C, 4'd8, 2'b00, 2'b00);
    din = 8'h3C; cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
    tx_start = 1'b1;
    step();
    wait_done(400, "b2b_done1");
    step();
    chk("b2b_no_gap", {31'd0, tx_busy}, 32'd1);
    tx_start = 1'b0;
    steps(20);
    tx_start = 1'b1; step(); tx_start = 1'b0;
    steps(30);
    tx_start = 1'b1; steps(3); tx_start = 1'b0;
    wait_done(400, "b2b_done2");
    chk("b2b_len", busy_cnt - b0, 32'd320);
    steps(200);
    chk("b2b_frames", done_cnt - d0, 32'd2);
    chk("b2b_idle", {31'd0, tx_busy}, 32'd0);

    // s_tick held low for 20 clocks inside data bit 1 of 0x96 (bit1 = 1).
    mon_en = 1'b0;
    b0 = busy_cnt;
    send(8'h96, 4'd8, 2'b00, 2'b00);
    steps(39);
    s_tick = 1'b0;
    steps(20);
    chk("hold_tx", {31'd0, tx}, 32'd1);
    chk("hold_busy", {31'd0, tx_busy}, 32'd1);
    s_tick = 1'b1;
    wait_done(400, "done_hold");
    chk("len_hold", busy_cnt - b0, 32'd180);

    // Reset mid-data: line high at once, no done pulse afterwards.
    send(8'hA5, 4'd8, 2'b00, 2'b00);
    steps(60);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_mid_done", {31'd0, tx_done_tick}, 32'd0);
    step();
    reset = 1'b0;
    d0 = done_cnt;
    exp_q.delete();
    mon_en = 1'b1;
    steps(250);
    chk("rst_no_done", done_cnt - d0, 32'd0);
    chk("rst_idle", {31'd0, tx_busy}, 32'd0);

`ifdef UART_TX_BREAK_EN
    // Break beats tx_start: 320 low, 16 high, one done, no data frame.
    b0 = busy_cnt; d0 = done_cnt;
    push_bits(1'b0, 320);
    push_bits(1'b1, 16);
    din = 8'hFF; cfg_dbits = 4'd8; cfg_parity = 2'b00; cfg_stop = 2'b00;
    send_break = 1'b1; tx_start = 1'b1;
    step();
    send_break = 1'b0; tx_start = 1'b0;
    wait_done(800, "brk_done");
    chk("brk_len", busy_cnt - b0, 32'd336);
    steps(50);
    chk("brk_frames", done_cnt - d0, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
